// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit-count width of the counter; never below 1 so the counter always exists.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generate/propagate.
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, LSB first, one bit per enabled clock.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_c;
  logic             br_c;

  // Single shared cell consumes the operand LSBs and the borrow flop.
  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_c),
    .bout (br_c)
  );

  // FSM, datapath shift registers and registered outputs; diff is the result shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          diff <= {d_c, diff[WIDTH-1:1]};
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          br   <= br_c;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bout  <= br_c;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=3.
module tb_serial_subtractor;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic       start = 1'b0;
  logic       bin   = 1'b0;
  logic [7:0] a     = 8'h00;
  logic [7:0] b     = 8'h00;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic       ena3   = 1'b1;
  logic       start3 = 1'b0;
  logic       bin3   = 1'b0;
  logic [2:0] a3     = 3'd0;
  logic [2:0] b3     = 3'd0;
  logic       busy3, done3, bout3;
  logic [2:0] diff3;

  int errors = 0;
  int checks = 0;
  logic [8:0] q8[$];
  logic [3:0] q3[$];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena3), .start(start3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - 9'(c);
  endfunction

  function automatic logic [3:0] model3(input logic [2:0] x, input logic [2:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - 4'(c);
  endfunction

  // Monitor for the 8-bit instance: one result per enabled DONE cycle.
  always @(negedge clk) begin
    if (rst_n && ena && done) begin
      if (q8.size() == 0) check("unexpected_done8", 1, 0);
      else check("result8", int'({bout, diff}), int'(q8.pop_front()));
    end
  end

  // Monitor for the 3-bit instance.
  always @(negedge clk) begin
    if (rst_n && ena3 && done3) begin
      if (q3.size() == 0) check("unexpected_done3", 1, 0);
      else check("result3", int'({bout3, diff3}), int'(q3.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one operation from IDLE and track latency, busy and done cycles.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic [8:0] exp, output int lat, output int bcnt, output int dcnt);
    lat  = -1;
    bcnt = 0;
    dcnt = 0;
    a = av; b = bv; bin = cv; start = 1'b1;
    q8.push_back(exp);
    @(posedge clk);
    for (int e = 1; e <= 60; e++) begin
      #1;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat < 0) lat = e - 1;
      end
      #1;
      if (e == 1) start = 1'b0;
      if (e > 1 && !busy) break;
      @(posedge clk);
    end
  endtask

  int lat, bcnt, dcnt;

  initial begin
    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(bout), 0);
    check("rst_busy3", int'(busy3), 0);
    tick();

    // Basic subtract
    run_op(8'h5A, 8'h3C, 1'b0, 9'h01E, lat, bcnt, dcnt);
    check("basic_latency", lat, 8);
    check("basic_busy_cycles", bcnt, 9);
    check("basic_done_cycles", dcnt, 1);

    // Underflow cases
    run_op(8'h00, 8'h01, 1'b0, 9'h1FF, lat, bcnt, dcnt);
    check("uflow1_latency", lat, 8);
    run_op(8'h10, 8'h10, 1'b1, 9'h1FF, lat, bcnt, dcnt);
    check("uflow2_latency", lat, 8);
    tick();
    check("hold_diff", int'(diff), 8'hFF);
    check("hold_bout", int'(bout), 1);

    // Enable stall for 3 cycles during SHIFT
    fork
      run_op(8'hFF, 8'h0F, 1'b0, 9'h0F0, lat, bcnt, dcnt);
      begin
        repeat (3) tick();
        ena = 1'b0;
        repeat (3) tick();
        ena = 1'b1;
      end
    join
    check("stall_latency", lat, 11);
    check("stall_busy_cycles", bcnt, 12);
    check("stall_done_cycles", dcnt, 1);

    // Start while busy is ignored
    fork
      run_op(8'h80, 8'h01, 1'b0, 9'h07F, lat, bcnt, dcnt);
      begin
        repeat (3) tick();
        a = 8'h01; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
      end
    join
    check("busy_start_latency", lat, 8);
    check("busy_start_done_cycles", dcnt, 1);
    tick();
    check("busy_start_not_queued", int'(busy), 0);

    // Reset mid-operation
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_diff", int'(diff), 0);
    check("midrst_bout", int'(bout), 0);
    repeat (12) tick();
    check("midrst_no_done", int'(done), 0);
    run_op(8'h33, 8'h11, 1'b0, 9'h022, lat, bcnt, dcnt);
    check("after_rst_latency", lat, 8);

    // Back-to-back random operations with start held high
    fork
      begin
        start = 1'b1;
        for (int n = 0; n < 1000; n++) begin
          a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
          q8.push_back(model8(a, b, bin));
          repeat (10) @(posedge clk);
          #2;
        end
        start = 1'b0;
      end
      begin
        start3 = 1'b1;
        for (int n = 0; n < 1000; n++) begin
          a3 = 3'($urandom); b3 = 3'($urandom); bin3 = 1'($urandom);
          q3.push_back(model3(a3, b3, bin3));
          repeat (5) @(posedge clk);
          #2;
        end
        start3 = 1'b0;
      end
    join

    // Drain: every expected result must have been presented
    for (int i = 0; i < 40 && (q8.size() != 0 || q3.size() != 0); i++) tick();
    check("drain_q8", q8.size(), 0);
    check("drain_q3", q3.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing `a - b - bin` one bit per enabled clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the counterpart of the design's full-adder cell: it recovers differences where the adder forms sums, and it trades area for WIDTH cycles of latency. It sits in the Tiny Tapeout user area. Operands come in as a parallel load. The result is presented in parallel with a one-cycle completion pulse.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..16.

Ports:
- `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
- `rst_n`: input, 1 bit. Synchronous, active-low reset: one clock, reset is synchronous and active-low.
- `ena`: input, 1 bit, clock enable; when low, all state is frozen.
- `start`: input, 1 bit, load request; sampled only in IDLE with `ena` high.
- `a`: input, WIDTH bits, minuend; captured on accepted `start`.
- `b`: input, WIDTH bits, subtrahend; captured on accepted `start`.
- `bin`: input, 1 bit, borrow-in; captured on accepted `start`.
- `busy`: output, 1 bit, high in SHIFT and DONE.
- `done`: output, 1 bit, high for exactly one enabled cycle, in DONE.
- `diff`: output, WIDTH bits, result `(a - b - bin) mod 2^WIDTH`.
- `bout`: output, 1 bit, final borrow; 1 iff `a < b + bin` (unsigned).

## Operation
- **States:** IDLE, SHIFT, DONE.
- **Reset:** `rst_n` low at a rising edge puts the block in IDLE. It clears the operand shift registers, result register, borrow flop and counter, so `busy`=0, `done`=0, `diff`=0, `bout`=0. Reset has priority over `ena` and aborts any operation in progress.
- **IDLE:** `start`=1 with `ena`=1 loads `a`, `b`, `bin` into the borrow flop, clears the counter, and moves to SHIFT. `diff`/`bout` keep the previous result until the first SHIFT cycle.
- **SHIFT:** each enabled cycle does the following.
  - Cell inputs are `a_sr[0]`, `b_sr[0]` and the borrow flop.
  - Cell outputs: `d = a^b^br`; `br' = (~a & b) | (~(a^b) & br)`.
  - The result register shifts right with `d` entering the MSB.
  - Both operand registers shift right (zero fill), and the counter increments.
  - When the counter reaches WIDTH-1, the same edge moves the state to DONE.
- **DONE:** `done`=1, `diff` equals the result register and `bout` equals the borrow flop. The next enabled edge returns to IDLE.
- **Output holding:** `diff` and `bout` hold their values until the next accepted `start`.
- **Ignored starts:** `start` in SHIFT or DONE is ignored and not queued.
- **`ena` low:** no state, counter, shift or output change. `done` stays high if frozen in DONE.
- **Arithmetic:** unsigned modulo 2^WIDTH; no saturation.

## Timing
- Latency: with `start` accepted at edge E0, SHIFT occupies edges E1..E_WIDTH, all enabled. `done` is high in the cycle following E_WIDTH, which is WIDTH enabled cycles after acceptance.
- Each `ena`-low cycle adds exactly one cycle to the latency.
- Throughput: one operation per WIDTH+2 enabled cycles. A `start` held high continuously is re-accepted in the first IDLE cycle after DONE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `serial_subtractor_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE) with a 2-bit encoding;
  - the default `WIDTH` constant;
  - the counter-width function `$clog2(WIDTH)`.
- Sub-module `full_subtractor` is the combinational cell, with ports `a`, `b`, `bin` → `d`, `bout`. It is instantiated once in the datapath.
- The top level contains the FSM, the counter, two operand shift registers, the result shift register and the borrow flop.

## Test plan
- **Basic subtract:** `a`=0x5A, `b`=0x3C, `bin`=0, `start` for 1 cycle → `done` pulse 8 cycles later, `diff`=0x1E, `bout`=0, `busy` high for 9 cycles.
- **Underflow:** `a`=0x00, `b`=0x01, `bin`=0 → `diff`=0xFF, `bout`=1. Then `a`=0x10, `b`=0x10, `bin`=1 → `diff`=0xFF, `bout`=1.
- **Enable stall:** `ena` low for 3 cycles during SHIFT with `a`=0xFF, `b`=0x0F → `done` arrives 11 cycles after `start`, `diff`=0xF0, `bout`=0, and `done` stays single-cycle.
- **Start while busy:** second `start` (`a`=0x01, `b`=0x01) issued 3 cycles into an operation on 0x80-0x01 → ignored; result is `diff`=0x7F, `bout`=0, with exactly one `done`.
- **Reset mid-operation:** `rst_n` low for 1 cycle at SHIFT cycle 4 → next cycle shows IDLE, `busy`=0, `diff`=0, `bout`=0, and no `done`. A new `start` then completes normally.
- **Randomised check:** 1000 random `a`/`b`/`bin` operations back-to-back with `start` held high, each compared against `{bout,diff} = {1'b0,a} - b - bin` mod 2^(WIDTH+1), with `bout` taken as the inverted carry. Run for `WIDTH`=8 and `WIDTH`=3.
